// File: rtl/led_pkg.sv
// Shared types for the motion-direction LED indicator: FSM states, input code
// classes and a counter-width helper.
package led_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACTIVE,
      ST_HOLD,
      ST_FAULT
   } led_state_t;

   typedef enum logic [1:0] {
      DC_ZERO,
      DC_ONEHOT,
      DC_MULTI
   } dir_class_t;

   // Bits needed to hold values 0..limit-1, never less than one.
   function automatic int cnt_width(input int limit);
      return (limit > 1) ? $clog2(limit) : 1;
   endfunction

endpackage

// File: rtl/led_blink_prescaler.sv
// Free-running blink timebase: counts 0..DIV-1 and toggles phase on every wrap.
module led_blink_prescaler
   import led_pkg::*;
#(
   parameter int DIV = 25_000_000
)(
   input  logic clk,
   input  logic rst_n,
   output logic phase
);

   localparam int            CW   = cnt_width(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (cnt == LAST) begin
         cnt   <= '0;
         phase <= ~phase;
      end else begin
         cnt   <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/led_motion_indicator.sv
// Motion-direction LED driver: one LED per direction, solid or blinking, with
// hold-after-motion and fault reporting for persistent multi-hot codes.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | no motion, LEDs dark
//   ST_ACTIVE | motion seen, latched direction shown solid or blinking
//   ST_HOLD   | motion stopped, latched direction blinks for HOLD_CYCLES
//   ST_FAULT  | multi-hot code persisted, all LEDs flash until acknowledged
module led_motion_indicator
   import led_pkg::*;
#(
   parameter int NUM_DIRS    = 4,
   parameter int BLINK_DIV   = 25_000_000,
   parameter int HOLD_CYCLES = 50_000_000,
   parameter int ERR_PERSIST = 16
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_DIRS-1:0] motiondir,
   input  logic                blink_en,
   input  logic                fault_clr,
   output logic [NUM_DIRS-1:0] led,
   output logic                fault
);

   localparam int                HOLD_W    = cnt_width(HOLD_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   // The error counter has to represent the saturation value itself.
   localparam int                ERR_W     = cnt_width(ERR_PERSIST + 1);
   localparam logic [ERR_W-1:0]  ERR_LIM   = ERR_W'(ERR_PERSIST);
   localparam logic [NUM_DIRS-1:0] DIR_ONE = {{(NUM_DIRS-1){1'b0}}, 1'b1};

   led_state_t          state;
   dir_class_t          cls;
   logic [NUM_DIRS-1:0] dir_q;
   logic [NUM_DIRS-1:0] lat;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [ERR_W-1:0]    err_cnt;
   logic [ERR_W-1:0]    err_inc;
   logic                fault_hit;
   logic                phase;
   logic [NUM_DIRS-1:0] on_lat;
   logic [NUM_DIRS-1:0] on_new;
   logic [NUM_DIRS-1:0] shown_new;
   logic [NUM_DIRS-1:0] flash;

   led_blink_prescaler #(.DIV(BLINK_DIV)) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .phase (phase)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dir_q <= '0;
      else        dir_q <= motiondir;
   end

   always_comb begin
      if (dir_q == '0)                              cls = DC_ZERO;
      else if ((dir_q & (dir_q - DIR_ONE)) == '0)   cls = DC_ONEHOT;
      else                                          cls = DC_MULTI;
   end

   assign err_inc   = (err_cnt == ERR_LIM) ? err_cnt : err_cnt + ERR_W'(1);
   assign fault_hit = (cls == DC_MULTI) && (err_inc == ERR_LIM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                err_cnt <= '0;
      else if (cls == DC_MULTI)  err_cnt <= err_inc;
      else                       err_cnt <= '0;
   end

   // LED patterns for the value the latch holds now and for a fresh relatch.
   assign on_lat    = phase ? lat   : '0;
   assign on_new    = phase ? dir_q : '0;
   assign shown_new = blink_en ? on_new : dir_q;
   assign flash     = {NUM_DIRS{phase}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         lat      <= '0;
         hold_cnt <= '0;
         led      <= '0;
         fault    <= 1'b0;
      end else if (state != ST_FAULT && fault_hit) begin
         state <= ST_FAULT;
         led   <= flash;
         fault <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cls == DC_ONEHOT) begin
                  state <= ST_ACTIVE;
                  lat   <= dir_q;
                  led   <= shown_new;
               end else begin
                  led   <= '0;
               end
            end
            ST_ACTIVE: begin
               if (cls == DC_ZERO) begin
                  state    <= ST_HOLD;
                  hold_cnt <= '0;
                  led      <= on_lat;
               end else if (cls == DC_ONEHOT) begin
                  lat      <= dir_q;
                  led      <= shown_new;
               end else begin
                  led      <= blink_en ? on_lat : lat;
               end
            end
            ST_HOLD: begin
               if (cls == DC_ONEHOT) begin
                  state <= ST_ACTIVE;
                  lat   <= dir_q;
                  led   <= shown_new;
               end else if (cls == DC_ZERO && hold_cnt == HOLD_LAST) begin
                  state <= ST_IDLE;
                  led   <= '0;
               end else begin
                  if (cls == DC_ZERO) hold_cnt <= hold_cnt + HOLD_W'(1);
                  led   <= on_lat;
               end
            end
            ST_FAULT: begin
               if (fault_clr && cls == DC_ZERO) begin
                  state <= ST_IDLE;
                  led   <= '0;
                  fault <= 1'b0;
               end else begin
                  led   <= flash;
               end
            end
            default: begin
               state <= ST_IDLE;
               led   <= '0;
               fault <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_motion_indicator.sv
// Self-checking bench for led_motion_indicator against a cycle-level behavioural model.
module tb_led_motion_indicator;

   localparam int NUM_DIRS    = 4;
   localparam int BLINK_DIV   = 4;
   localparam int HOLD_CYCLES = 8;
   localparam int ERR_PERSIST = 3;

   localparam int M_IDLE   = 0;
   localparam int M_ACTIVE = 1;
   localparam int M_HOLD   = 2;
   localparam int M_FAULT  = 3;

   logic                clk;
   logic                rst_n;
   logic [NUM_DIRS-1:0] motiondir;
   logic                blink_en;
   logic                fault_clr;
   logic [NUM_DIRS-1:0] led;
   logic                fault;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [NUM_DIRS-1:0] m_dq;
   logic [NUM_DIRS-1:0] m_lat;
   logic [NUM_DIRS-1:0] m_led;
   logic                m_fault;
   int                  m_mode;
   int                  m_hold_left;
   int                  m_run;
   int                  edges;

   led_motion_indicator #(
      .NUM_DIRS    (NUM_DIRS),
      .BLINK_DIV   (BLINK_DIV),
      .HOLD_CYCLES (HOLD_CYCLES),
      .ERR_PERSIST (ERR_PERSIST)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .motiondir (motiondir),
      .blink_en  (blink_en),
      .fault_clr (fault_clr),
      .led       (led),
      .fault     (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_dq = '0; m_lat = '0; m_led = '0; m_fault = 1'b0;
      m_mode = M_IDLE; m_hold_left = 0; m_run = 0; edges = 0;
   endtask

   // One rising edge of the model, using the inputs present at that edge.
   task automatic model_edge();
      int ph;
      int ones;
      ph = (edges / BLINK_DIV) % 2;
      edges++;
      ones = $countones(m_dq);
      m_run = (ones > 1) ? m_run + 1 : 0;
      if (m_mode != M_FAULT && ones > 1 && m_run >= ERR_PERSIST) begin
         m_mode = M_FAULT;
      end else if (m_mode == M_IDLE) begin
         if (ones == 1) begin m_mode = M_ACTIVE; m_lat = m_dq; end
      end else if (m_mode == M_ACTIVE) begin
         if (ones == 1) m_lat = m_dq;
         else if (ones == 0) begin m_mode = M_HOLD; m_hold_left = HOLD_CYCLES; end
      end else if (m_mode == M_HOLD) begin
         if (ones == 1) begin m_mode = M_ACTIVE; m_lat = m_dq; end
         else if (ones == 0) begin
            m_hold_left--;
            if (m_hold_left == 0) m_mode = M_IDLE;
         end
      end else begin
         if (fault_clr && ones == 0) m_mode = M_IDLE;
      end
      m_dq = motiondir;
      case (m_mode)
         M_ACTIVE: m_led = (blink_en && ph == 0) ? '0 : m_lat;
         M_HOLD:   m_led = (ph == 1) ? m_lat : '0;
         M_FAULT:  m_led = (ph == 1) ? '1 : '0;
         default:  m_led = '0;
      endcase
      m_fault = (m_mode == M_FAULT);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; motiondir = '0; blink_en = 1'b0; fault_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (led !== 4'b0000 || fault !== 1'b0) begin
         errors++;
         $display("FAIL reset_init: led=%b fault=%b expected led=0000 fault=0", led, fault);
      end
      rst_n = 1'b1;
      model_reset();
      motiondir = 4'b0100;
      repeat (4) step();
      checks++;
      if (led !== 4'b0100) begin
         errors++;
         $display("FAIL reset_pre_active: led=%b expected 0100", led);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (led !== 4'b0000 || fault !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: led=%b fault=%b expected led=0000 fault=0", led, fault);
      end
      @(posedge clk);
      #2;
      motiondir = '0;
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (led !== 4'b0000) begin
            errors++;
            $display("FAIL reset_after_release: cycle %0d led=%b expected 0000", i, led);
         end
      end
   endtask

   task automatic test_solid();
      blink_en = 1'b0;
      motiondir = 4'b0010;
      step();
      checks++;
      if (led !== 4'b0000) begin
         errors++;
         $display("FAIL solid_edge1: led=%b expected 0000", led);
      end
      step();
      checks++;
      if (led !== 4'b0010) begin
         errors++;
         $display("FAIL solid_edge2: led=%b expected 0010", led);
      end
      motiondir = 4'b1000;
      step();
      checks++;
      if (led !== 4'b0010) begin
         errors++;
         $display("FAIL solid_change_edge1: led=%b expected 0010", led);
      end
      step();
      checks++;
      if (led !== 4'b1000) begin
         errors++;
         $display("FAIL solid_change_edge2: led=%b expected 1000", led);
      end
   endtask

   task automatic test_blink();
      blink_en = 1'b1;
      motiondir = 4'b0001;
      for (int i = 0; i < 24; i++) begin
         step();
         checks++;
         if (led !== m_led) begin
            errors++;
            $display("FAIL blink: cycle %0d led=%b expected %b", i, led, m_led);
         end
      end
   endtask

   task automatic test_hold();
      blink_en = 1'b0;
      motiondir = 4'b0100;
      repeat (3) step();
      motiondir = 4'b0000;
      step();
      for (int i = 0; i < HOLD_CYCLES; i++) begin
         step();
         checks++;
         if (led !== m_led || m_mode != M_HOLD) begin
            errors++;
            $display("FAIL hold_blink: cycle %0d led=%b expected %b", i, led, m_led);
         end
      end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (led !== 4'b0000) begin
            errors++;
            $display("FAIL hold_expire: cycle %0d led=%b expected 0000", i, led);
         end
      end
      motiondir = 4'b0100;
      repeat (3) step();
      motiondir = 4'b0000;
      step();
      repeat (5) step();
      motiondir = 4'b0100;
      step();
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (led !== 4'b0100) begin
            errors++;
            $display("FAIL hold_reassert: cycle %0d led=%b expected 0100", i, led);
         end
      end
   endtask

   task automatic test_fault();
      logic saw_on;
      logic saw_off;
      blink_en = 1'b0;
      motiondir = 4'b0011;
      repeat (2) step();
      motiondir = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (fault !== 1'b0) begin
            errors++;
            $display("FAIL fault_short_burst: cycle %0d fault=%b expected 0", i, fault);
         end
      end
      motiondir = 4'b0011;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (fault !== (i == 3)) begin
            errors++;
            $display("FAIL fault_entry: cycle %0d fault=%b expected %b", i, fault, (i == 3));
         end
      end
      fault_clr = 1'b1;
      saw_on = 1'b0;
      saw_off = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (led === 4'b1111) saw_on = 1'b1;
         if (led === 4'b0000) saw_off = 1'b1;
         checks++;
         if (fault !== 1'b1 || led !== m_led) begin
            errors++;
            $display("FAIL fault_hold: cycle %0d fault=%b led=%b expected fault=1 led=%b", i, fault, led, m_led);
         end
      end
      checks++;
      if (!(saw_on && saw_off)) begin
         errors++;
         $display("FAIL fault_flash: saw 1111=%b saw 0000=%b expected both 1", saw_on, saw_off);
      end
      fault_clr = 1'b0;
      motiondir = 4'b0000;
      step();
      checks++;
      if (fault !== 1'b1) begin
         errors++;
         $display("FAIL fault_no_clr: fault=%b expected 1", fault);
      end
      fault_clr = 1'b1;
      step();
      fault_clr = 1'b0;
      checks++;
      if (fault !== 1'b0 || led !== 4'b0000) begin
         errors++;
         $display("FAIL fault_clear: fault=%b led=%b expected fault=0 led=0000", fault, led);
      end
   endtask

   task automatic test_glitch();
      logic [NUM_DIRS-1:0] seq [12];
      seq = '{4'b0001, 4'b0001, 4'b0110, 4'b0001, 4'b0001,
              4'b0110, 4'b0110, 4'b0001, 4'b0110, 4'b0110, 4'b0001, 4'b0001};
      blink_en = 1'b0;
      motiondir = 4'b0001;
      repeat (3) step();
      for (int i = 0; i < 12; i++) begin
         motiondir = seq[i];
         step();
         checks++;
         if (led !== 4'b0001 || fault !== 1'b0) begin
            errors++;
            $display("FAIL glitch: cycle %0d led=%b fault=%b expected led=0001 fault=0", i, led, fault);
         end
      end
   endtask

   task automatic test_random();
      int run;
      int i;
      logic [NUM_DIRS-1:0] val;
      i = 0;
      while (i < 400) begin
         run = $urandom_range(1, 12);
         case ($urandom_range(0, 3))
            0:       val = 4'b0000;
            1, 2:    val = 4'(1) << $urandom_range(0, 3);
            default: val = 4'($urandom_range(0, 15));
         endcase
         for (int k = 0; k < run; k++) begin
            motiondir = val;
            if ($urandom_range(0, 9) == 0) blink_en = ~blink_en;
            fault_clr = ($urandom_range(0, 3) == 0);
            step();
            i++;
            checks++;
            if (led !== m_led || fault !== m_fault) begin
               errors++;
               $display("FAIL random: cycle %0d led=%b fault=%b expected led=%b fault=%b",
                        i, led, fault, m_led, m_fault);
            end
         end
      end
      fault_clr = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; motiondir = '0; blink_en = 1'b0; fault_clr = 1'b0;
      model_reset();
      test_reset();
      test_solid();
      test_blink();
      test_hold();
      test_fault();
      test_glitch();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
